// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing generator: pixel-enable divider, h/v counters,
// registered syncs aligned with pixel_x/pixel_y, and a start-of-frame strobe.
module vga_sync_gen #(
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter int unsigned CLK_DIV   = 4
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       p_tick,
    output logic       frame_tick
);

    localparam int unsigned CNT_W   = 10;
    localparam int unsigned DIV_W   = $clog2(CLK_DIV);
    localparam int unsigned H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_DISPLAY);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_DISPLAY);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_DISPLAY + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_DISPLAY + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_DISPLAY + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_DISPLAY + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             tick_c;
    logic             h_end_c;
    logic             v_end_c;

    assign tick_c  = (div_q == DIV_LAST);
    // >= rather than == so any out-of-range count wraps on its next advance
    assign h_end_c = (h_q >= H_LAST);
    assign v_end_c = (v_q >= V_LAST);

    // Next-state counts; syncs are decoded from them so they land with the counts
    always_comb begin
        div_d   = div_q + DIV_W'(1);
        h_d     = h_q;
        v_d     = v_q;
        if (tick_c) begin
            h_d = h_end_c ? '0 : h_q + CNT_W'(1);
            if (h_end_c) begin
                v_d = v_end_c ? '0 : v_q + CNT_W'(1);
            end
        end
        hsync_d = !((h_d >= HS_FIRST) && (h_d <= HS_LAST));
        vsync_d = !((v_d >= VS_FIRST) && (v_d <= VS_LAST));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q   <= '0;
            h_q     <= '0;
            v_q     <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            div_q   <= div_d;
            h_q     <= h_d;
            v_q     <= v_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign pixel_x    = h_q;
    assign pixel_y    = v_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign p_tick     = tick_c;
    assign video_on   = (h_q < H_VIS) && (v_q < V_VIS);
    assign frame_tick = tick_c && h_end_c && v_end_c;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default horizontal timing (dut_a) and the CLK_DIV=2
// 320/8/48/24 variant (dut_b), both with a short 7-line frame to keep runs brief.
module tb_vga_sync_gen;

    localparam int A_HD = 640, A_HFP = 16, A_HS = 96, A_HBP = 48, A_DIV = 4;
    localparam int B_HD = 320, B_HFP = 8,  B_HS = 48, B_HBP = 24, B_DIV = 2;
    localparam int VD = 3, VFP = 1, VS = 2, VBP = 1;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       von;
        logic       hs;
        logic       vs;
        logic       pt;
        logic       ft;
    } obs_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [9:0] a_px, a_py, b_px, b_py;
    logic a_von, a_hs, a_vs, a_pt, a_ft;
    logic b_von, b_hs, b_vs, b_pt, b_ft;

    vga_sync_gen #(
        .H_DISPLAY(A_HD), .H_FP(A_HFP), .H_SYNC(A_HS), .H_BP(A_HBP),
        .V_DISPLAY(VD), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .CLK_DIV(A_DIV)
    ) dut_a (
        .clk(clk), .reset(reset), .pixel_x(a_px), .pixel_y(a_py),
        .video_on(a_von), .hsync(a_hs), .vsync(a_vs), .p_tick(a_pt),
        .frame_tick(a_ft)
    );

    vga_sync_gen #(
        .H_DISPLAY(B_HD), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
        .V_DISPLAY(VD), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .CLK_DIV(B_DIV)
    ) dut_b (
        .clk(clk), .reset(reset), .pixel_x(b_px), .pixel_y(b_py),
        .video_on(b_von), .hsync(b_hs), .vsync(b_vs), .p_tick(b_pt),
        .frame_tick(b_ft)
    );

    obs_t a_obs, b_obs;
    assign a_obs = {a_px, a_py, a_von, a_hs, a_vs, a_pt, a_ft};
    assign b_obs = {b_px, b_py, b_von, b_hs, b_vs, b_pt, b_ft};

    int     checks = 0;
    int     errors = 0;
    longint k = 0;
    bit     model_ok = 1'b0;

    // k = clk edges since the last edge that saw reset high
    always @(posedge clk) begin
        if (reset) begin
            k        <= 0;
            model_ok <= 1'b1;
        end else begin
            k <= k + 1;
        end
    end

    // Timing from elapsed clocks: completed ticks -> raster position
    function automatic obs_t model(longint kk, int hd, int hfp, int hsw, int hbp, int div);
        obs_t   m;
        longint ht  = longint'(hd + hfp + hsw + hbp);
        longint vt  = longint'(VD + VFP + VS + VBP);
        longint pos = (kk / div) % (ht * vt);
        int     x   = int'(pos % ht);
        int     y   = int'(pos / ht);
        m.x   = 10'(x);
        m.y   = 10'(y);
        m.von = (x < hd) && (y < VD);
        m.hs  = !((x >= hd + hfp) && (x < hd + hfp + hsw));
        m.vs  = !((y >= VD + VFP) && (y < VD + VFP + VS));
        m.pt  = (kk % div) == longint'(div - 1);
        m.ft  = m.pt && (x == int'(ht) - 1) && (y == int'(vt) - 1);
        return m;
    endfunction

    task automatic cmp_obs(string name, obs_t act, obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s k=%0d act x=%0d y=%0d von=%b hs=%b vs=%b pt=%b ft=%b exp x=%0d y=%0d von=%b hs=%b vs=%b pt=%b ft=%b",
                     name, k, act.x, act.y, act.von, act.hs, act.vs, act.pt, act.ft,
                     exp.x, exp.y, exp.von, exp.hs, exp.vs, exp.pt, exp.ft);
        end
    endtask

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic check_reset(string name);
        chk({name, "_px"}, longint'(a_px), 0);
        chk({name, "_py"}, longint'(a_py), 0);
        chk({name, "_von"}, longint'(a_von), 1);
        chk({name, "_hs"}, longint'(a_hs), 1);
        chk({name, "_vs"}, longint'(a_vs), 1);
        chk({name, "_pt"}, longint'(a_pt), 0);
        chk({name, "_ft"}, longint'(a_ft), 0);
        chk({name, "_b_pos"}, longint'({b_px, b_py}), 0);
    endtask

    // Every-cycle comparison against the model, stopped once errors pile up
    always @(negedge clk) begin
        if (model_ok && errors < 50) begin
            cmp_obs("dut_a", a_obs, model(k, A_HD, A_HFP, A_HS, A_HBP, A_DIV));
            cmp_obs("dut_b", b_obs, model(k, B_HD, B_HFP, B_HS, B_HBP, B_DIV));
        end
    end

    initial begin
        longint cyc;
        longint ft_k[2];
        longint b_ft_k;
        int     ft_seen;
        int     hs_low, vs_low, max_px, n;
        bit     found;

        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_reset("init_reset");

        reset = 1'b0;
        n = int'($urandom_range(20, 500));
        repeat (n) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset("reset_3clk");

        reset   = 1'b0;
        cyc     = 0;
        ft_seen = 0;
        b_ft_k  = -1;
        hs_low  = 0;
        vs_low  = 0;
        max_px  = 0;
        ft_k[0] = -1;
        ft_k[1] = -1;
        while (ft_seen < 2 && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            if (cyc <= 3) chk("first_ptick", longint'(a_pt), longint'(cyc == 3));
            if (cyc == 4) chk("px_after_first_tick", longint'(a_px), 1);
            if (cyc == 7) chk("second_ptick", longint'(a_pt), 1);
            if (cyc == 2559) chk("von_at_639", longint'(a_von), 1);
            if (cyc == 2560) chk("von_at_640", longint'(a_von), 0);
            if (cyc == 2623) chk("hs_at_655", longint'(a_hs), 1);
            if (cyc == 2624) chk("hs_at_656", longint'(a_hs), 0);
            if (cyc == 3007) chk("hs_at_751", longint'(a_hs), 0);
            if (cyc == 3008) chk("hs_at_752", longint'(a_hs), 1);
            if (cyc == 6399) chk("line_end_799_1", longint'({a_px, a_py}), longint'({10'd799, 10'd1}));
            if (cyc == 6400) chk("line_wrap_0_2", longint'({a_px, a_py}), longint'({10'd0, 10'd2}));
            if (b_ft && b_ft_k < 0) b_ft_k = cyc;
            if (ft_seen == 1) begin
                if (!a_hs) hs_low++;
                if (!a_vs) vs_low++;
            end
            if (a_ft) begin
                ft_k[ft_seen] = cyc;
                ft_seen++;
            end
            if (int'(a_px) > max_px) max_px = int'(a_px);
        end
        chk("frame_tick_count", longint'(ft_seen), 2);
        chk("first_frame_tick_clk", ft_k[0], 22399);
        chk("frame_period_clk", ft_k[1] - ft_k[0], 22400);
        chk("hsync_low_clk_per_frame", longint'(hs_low), 2688);
        chk("vsync_low_clk_per_frame", longint'(vs_low), 6400);
        chk("max_pixel_x_below_800", longint'(max_px < 800), 1);
        chk("b_first_frame_tick_clk", b_ft_k, 5599);

        // Reset coincident with a tick at (700,2)
        found = 1'b0;
        for (int i = 0; i < 30000 && !found; i++) begin
            @(negedge clk);
            if (a_px == 10'd700 && a_py == 10'd2 && a_pt) found = 1'b1;
        end
        chk("reach_700_2_tick", longint'(found), 1);
        reset = 1'b1;
        @(negedge clk);
        check_reset("mid_frame_reset");
        reset = 1'b0;

        cyc   = 0;
        found = 1'b0;
        while (!found && cyc < 30000) begin
            @(negedge clk);
            cyc++;
            if (a_ft) found = 1'b1;
        end
        chk("frame_tick_after_mid_reset", found ? cyc : -1, 22399);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
